// File: rtl/stoch_pkg.sv
// Shared types and constants for the stochastic arithmetic tile.
package stoch_pkg;

  typedef enum logic [1:0] {
    MODE_XNOR = 2'b00,
    MODE_MUX  = 2'b01,
    MODE_AND  = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_RUN  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  localparam int          LFSR_LEN      = 31;
  localparam int          LFSR_TAP      = 28;
  localparam logic [30:0] LFSR_SEED_DEF = 31'd134995;

  // x^31 + x^28 + 1, shifting towards the MSB.
  function automatic logic [LFSR_LEN-1:0] lfsr_next(input logic [LFSR_LEN-1:0] s);
    return {s[LFSR_LEN-2:0], s[LFSR_LEN-1] ^ s[LFSR_TAP-1]};
  endfunction

endpackage

// File: rtl/stoch_lfsr31.sv
// Free-running seedable 31-bit Fibonacci LFSR; advances every cycle.
module stoch_lfsr31
  import stoch_pkg::*;
#(
  parameter logic [LFSR_LEN-1:0] SEED = LFSR_SEED_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic [LFSR_LEN-1:0] lfsr_o
);

  logic [LFSR_LEN-1:0] lfsr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= SEED;
    else        lfsr_q <= lfsr_next(lfsr_q);
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/stoch_arith_core.sv
// Stochastic arithmetic core: serial operand load, bitstream combine, windowed ones count.
// Optional STOCH_UNIPOLAR_EN enables the AND (unipolar multiply) path for mode 10.
module stoch_arith_core
  import stoch_pkg::*;
#(
  parameter int          WIDTH     = 9,
  parameter int          WIN_LOG2  = 17,
  parameter logic [30:0] LFSR_SEED = LFSR_SEED_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [1:0]       mode,
  input  logic             ser_a,
  input  logic             ser_b,
  output logic             busy,
  output logic             sn_out,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             result_valid
);

  state_e              state_q, state_d;
  logic [1:0]          mode_q, mode_d;
  logic [WIDTH-1:0]    a_q, a_d, b_q, b_d;
  logic [WIN_LOG2-1:0] cnt_q, cnt_d;
  logic [WIN_LOG2:0]   ones_q, ones_d;
  logic [WIDTH-1:0]    res_q, res_d;
  logic                ovf_q, ovf_d;
  logic                sn_q;

  logic [LFSR_LEN-1:0] lfsr;
  logic                a_bit, b_bit, sel, comb_bit;
  logic                unused_lfsr;

  stoch_lfsr31 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .lfsr_o (lfsr)
  );

  // Two disjoint LFSR fields decorrelate the operand streams; bit 30 drives the MUX select.
  assign a_bit       = lfsr[WIDTH-1:0] < a_q;
  assign b_bit       = lfsr[WIDTH+10:11] < b_q;
  assign sel         = lfsr[30];
  assign unused_lfsr = ^lfsr;

  always_comb begin
    comb_bit = ~(a_bit ^ b_bit);
    case (mode_q)
      MODE_MUX: comb_bit = sel ? b_bit : a_bit;
`ifdef STOCH_UNIPOLAR_EN
      MODE_AND: comb_bit = a_bit & b_bit;
`endif
      default:  comb_bit = ~(a_bit ^ b_bit);
    endcase
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    ones_d  = ones_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          mode_d  = mode;
          a_d     = {ser_a, a_q[WIDTH-1:1]};
          b_d     = {ser_b, b_q[WIDTH-1:1]};
          cnt_d   = WIN_LOG2'(1);
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        a_d = {ser_a, a_q[WIDTH-1:1]};
        b_d = {ser_b, b_q[WIDTH-1:1]};
        if (cnt_q == WIN_LOG2'(WIDTH-1)) begin
          cnt_d   = '0;
          ones_d  = '0;
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        ones_d = ones_q + {{WIN_LOG2{1'b0}}, comb_bit};
        cnt_d  = cnt_q + 1'b1;
        if (&cnt_q) begin
          // Only a full window of ones can set the top count bit.
          if (ones_d[WIN_LOG2]) begin
            res_d = '1;
            ovf_d = 1'b1;
          end else begin
            res_d = ones_d[WIN_LOG2-1 -: WIDTH];
            ovf_d = 1'b0;
          end
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mode_q  <= 2'b00;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      ones_q  <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      sn_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      ones_q  <= ones_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      sn_q    <= comb_bit;
    end
  end

  assign busy         = (state_q != ST_IDLE);
  assign result_valid = (state_q == ST_DONE);
  assign sn_out       = sn_q;
  assign result       = res_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_stoch_arith_core.sv
// Scoreboard bench for stoch_arith_core at WIDTH=4, WIN_LOG2=8.
module tb_stoch_arith_core;

  localparam int          W    = 4;
  localparam int          WL   = 8;
  localparam int          WIN  = 256;
  localparam logic [30:0] SEED = 31'd134995;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         load = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic         ser_a = 1'b0;
  logic         ser_b = 1'b0;
  logic         busy, sn_out, overflow, result_valid;
  logic [W-1:0] result;

  stoch_arith_core #(.WIDTH(W), .WIN_LOG2(WL), .LFSR_SEED(SEED)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load         (load),
    .mode         (mode),
    .ser_a        (ser_a),
    .ser_b        (ser_b),
    .busy         (busy),
    .sn_out       (sn_out),
    .result       (result),
    .overflow     (overflow),
    .result_valid (result_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic         ovf;
    int           tcyc;
    string        name;
  } exp_t;

  exp_t        q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  logic [30:0] mlfsr;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [30:0] step(input logic [30:0] s);
    return {s[29:0], s[30] ^ s[27]};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mlfsr <= SEED;
    else        mlfsr <= step(mlfsr);
  end

  // Reference: RUN cycles see lfsr states step^W .. step^(W+WIN-1) of the accept-cycle state.
  function automatic logic [W:0] model(input logic [1:0] m, input logic [W-1:0] a,
                                       input logic [W-1:0] b, input logic [30:0] l0);
    logic [30:0] l;
    logic [WL:0] cnt;
    logic        ab, bb, c;
    l   = l0;
    cnt = '0;
    for (int i = 0; i < W; i++) l = step(l);
    for (int i = 0; i < WIN; i++) begin
      ab = l[W-1:0] < a;
      bb = l[W+10:11] < b;
      case (m)
        2'b01:   c = l[30] ? bb : ab;
`ifdef STOCH_UNIPOLAR_EN
        2'b10:   c = ab & bb;
`endif
        default: c = ~(ab ^ bb);
      endcase
      cnt = cnt + {{WL{1'b0}}, c};
      l   = step(l);
    end
    if (cnt[WL]) return {1'b1, {W{1'b1}}};
    return {1'b0, cnt[WL-1 -: W]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT strobes a result.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && result_valid) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_valid: got result_valid=1 expected 0 (cycle %0d)", cyc);
      end else begin
        e = q.pop_front();
        chk({e.name, " result"}, 32'(result), 32'(e.res));
        chk({e.name, " overflow"}, 32'(overflow), 32'(e.ovf));
        chk({e.name, " valid_cycle"}, 32'(cyc), 32'(e.tcyc));
      end
    end else if (q.size() > 0 && cyc > q[0].tcyc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s timeout: got no result_valid expected one at cycle %0d", q[0].name, q[0].tcyc);
      void'(q.pop_front());
    end
  end

  // Called at a negedge where the next edge is an IDLE accept edge.
  task automatic issue(input logic [1:0] m, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit hand, input logic [W-1:0] hres, input logic hovf,
                       input string nm);
    exp_t      e;
    logic [W:0] r;
    load  = 1'b1;
    mode  = m;
    ser_a = a[0];
    ser_b = b[0];
    r     = hand ? {hovf, hres} : model(m, a, b, mlfsr);
    e.res  = r[W-1:0];
    e.ovf  = r[W];
    e.tcyc = cyc + W + WIN;
    e.name = nm;
    q.push_back(e);
    for (int i = 1; i < W; i++) begin
      @(negedge clk);
      load  = 1'b0;
      mode  = ~m;
      ser_a = a[i];
      ser_b = b[i];
    end
  endtask

  task automatic wait_valid(input string nm);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 2 * WIN + 50; i++) begin
      @(negedge clk);
      if (result_valid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk({nm, " wait_valid"}, 32'd0, 32'd1);
  endtask

  initial begin
    logic [W:0] r;
    int         n0;

    repeat (3) @(negedge clk);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset sn_out", 32'(sn_out), 32'd0);
    chk("reset result", 32'(result), 32'd0);
    chk("reset overflow", 32'(overflow), 32'd0);
    chk("reset result_valid", 32'(result_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Zero operands, XNOR: every combined bit is 1, full window saturates.
    issue(2'b00, 4'd0, 4'd0, 1'b1, 4'hF, 1'b1, "xnor_zero");
    repeat (10) @(negedge clk);
    chk("xnor_zero sn_out", 32'(sn_out), 32'd1);
    wait_valid("xnor_zero");
    @(negedge clk);

    // Zero operands, MUX: all zeros; busy spans accept+1 .. valid cycle.
    n0 = cyc;
    chk("mux_zero busy_before", 32'(busy), 32'd0);
    issue(2'b01, 4'd0, 4'd0, 1'b1, 4'h0, 1'b0, "mux_zero");
    chk("mux_zero busy_load", 32'(busy), 32'd1);
    repeat (10) @(negedge clk);
    chk("mux_zero sn_out", 32'(sn_out), 32'd0);
    wait_valid("mux_zero");
    chk("mux_zero busy_valid", 32'(busy), 32'd1);
    chk("mux_zero valid_offset", 32'(cyc - n0), 32'(W + WIN));
    @(negedge clk);
    chk("mux_zero busy_after", 32'(busy), 32'd0);

`ifdef STOCH_UNIPOLAR_EN
    issue(2'b10, 4'd0, 4'd15, 1'b1, 4'h0, 1'b0, "and_zero");
`else
    issue(2'b10, 4'd0, 4'd15, 1'b0, 4'h0, 1'b0, "and_as_xnor");
`endif
    wait_valid("mode10");
    @(negedge clk);

    // Half/half bipolar multiply: near the midpoint, and bit-exact to the model.
    r = model(2'b00, 4'd8, 4'd8, mlfsr);
    chk("half_half in_range", 32'((r[W-1:0] >= 4'd7) && (r[W-1:0] <= 4'd9) && !r[W]), 32'd1);
    issue(2'b00, 4'd8, 4'd8, 1'b0, 4'h0, 1'b0, "half_half");
    wait_valid("half_half");
    @(negedge clk);

    issue(2'b11, 4'd5, 4'd12, 1'b0, 4'h0, 1'b0, "mode11");
    wait_valid("mode11");
    @(negedge clk);
    issue(2'b01, 4'd12, 4'd3, 1'b0, 4'h0, 1'b0, "mux_mid");
    wait_valid("mux_mid");
    @(negedge clk);

    // Abort 100 cycles into RUN.
    issue(2'b00, 4'd8, 4'd8, 1'b0, 4'h0, 1'b0, "aborted");
    repeat (101) @(negedge clk);
    q.delete();
    rst_n = 1'b0;
    #1;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort sn_out", 32'(sn_out), 32'd0);
    chk("abort result", 32'(result), 32'd0);
    chk("abort overflow", 32'(overflow), 32'd0);
    chk("abort result_valid", 32'(result_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_abort busy", 32'(busy), 32'd0);

    // Fresh run after abort, with load pulsed in RUN and in DONE.
    issue(2'b01, 4'd9, 4'd4, 1'b0, 4'h0, 1'b0, "after_abort");
    repeat (50) @(negedge clk);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_valid("after_abort");
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (3) @(negedge clk);
    chk("done_pulse ignored busy", 32'(busy), 32'd0);

    // load held high from RUN through DONE: accepted on the following IDLE edge.
    issue(2'b00, 4'd3, 4'd7, 1'b0, 4'h0, 1'b0, "hold_first");
    repeat (20) @(negedge clk);
    load = 1'b1;
    wait_valid("hold_first");
    @(negedge clk);
    chk("hold idle busy", 32'(busy), 32'd0);
    issue(2'b10, 4'd13, 4'd10, 1'b0, 4'h0, 1'b0, "hold_second");
    chk("hold_second busy", 32'(busy), 32'd1);
    wait_valid("hold_second");
    repeat (3) @(negedge clk);
    chk("scoreboard drained", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
